// File: rtl/mmcm_rst_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mmcm_rst_pkg: state encodings and sizing helpers for the MMCM supervisor |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mmcm_rst_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RST_PULSE = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_2ff: single-bit two-flop synchronizer, async active-low clear to 0  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/mmcm_reset_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mmcm_reset_ctrl: MMCM reset pulse, lock qualification, retry/fail status |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mmcm_reset_ctrl
  import mmcm_rst_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 256,
  parameter int LOCK_TIMEOUT_CYC = 65535,
  parameter int MAX_RETRIES      = 7
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               soft_rst,
  input  logic               mmcm_locked,
  output logic               mmcm_rst,
  output logic               clk_ready,
  output logic               fail,
  output logic [3:0]         retry_cnt,
  output logic [7:0]         loss_cnt,
  output logic [STATE_W-1:0] state
);

  localparam int PULSE_W  = cnt_w(RST_PULSE_CYC);
  localparam int STABLE_W = cnt_w(LOCK_STABLE_CYC);
  localparam int TMO_W    = cnt_w(LOCK_TIMEOUT_CYC);

  localparam logic [PULSE_W-1:0]  PULSE_LAST  = PULSE_W'(RST_PULSE_CYC - 1);
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYC - 1);
  localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [3:0]          RETRY_MAX   = 4'(MAX_RETRIES);

  logic lock_s;

  state_e              state_d, state_q;
  logic [PULSE_W-1:0]  pulse_cnt_d, pulse_cnt_q;
  logic [STABLE_W-1:0] stable_cnt_d, stable_cnt_q;
  logic [TMO_W-1:0]    tmo_cnt_d, tmo_cnt_q;
  logic [3:0]          retry_cnt_d, retry_cnt_q;
  logic [7:0]          loss_cnt_d, loss_cnt_q;
  logic                mmcm_rst_d, mmcm_rst_q;
  logic                clk_ready_d, clk_ready_q;
  logic                fail_d, fail_q;
  logic                tmo_fire;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (mmcm_locked),
    .q     (lock_s)
  );

  always_comb begin
    state_d      = state_q;
    pulse_cnt_d  = pulse_cnt_q;
    stable_cnt_d = stable_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    retry_cnt_d  = retry_cnt_q;
    loss_cnt_d   = loss_cnt_q;
    mmcm_rst_d   = mmcm_rst_q;
    clk_ready_d  = clk_ready_q;
    fail_d       = fail_q;
    tmo_fire     = 1'b0;

    if (soft_rst) begin
      state_d      = ST_RST_PULSE;
      pulse_cnt_d  = '0;
      stable_cnt_d = '0;
      tmo_cnt_d    = '0;
      retry_cnt_d  = '0;
      mmcm_rst_d   = 1'b1;
      clk_ready_d  = 1'b0;
      fail_d       = 1'b0;
    end else begin
      case (state_q)
        ST_RST_PULSE: begin
          mmcm_rst_d   = 1'b1;
          clk_ready_d  = 1'b0;
          stable_cnt_d = '0;
          tmo_cnt_d    = '0;
          if (pulse_cnt_q == PULSE_LAST) begin
            state_d     = ST_WAIT_LOCK;
            pulse_cnt_d = '0;
            mmcm_rst_d  = 1'b0;
          end else begin
            pulse_cnt_d = pulse_cnt_q + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (tmo_cnt_q == TMO_LAST) begin
            tmo_fire = 1'b1;
          end else if (lock_s) begin
            // The first synchronized-high cycle already counts toward stability.
            state_d      = ST_STABLE;
            stable_cnt_d = STABLE_W'(1);
          end
        end

        ST_STABLE: begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (lock_s && (stable_cnt_q == STABLE_LAST)) begin
            state_d      = ST_RUN;
            clk_ready_d  = 1'b1;
            stable_cnt_d = '0;
            tmo_cnt_d    = '0;
          end else if (tmo_cnt_q == TMO_LAST) begin
            tmo_fire = 1'b1;
          end else if (lock_s) begin
            stable_cnt_d = stable_cnt_q + 1'b1;
          end else begin
            state_d      = ST_WAIT_LOCK;
            stable_cnt_d = '0;
          end
        end

        ST_RUN: begin
          if (!lock_s) begin
            state_d     = ST_RST_PULSE;
            pulse_cnt_d = '0;
            mmcm_rst_d  = 1'b1;
            clk_ready_d = 1'b0;
            retry_cnt_d = '0;
            if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 1'b1;
          end
        end

        ST_FAIL: begin
          mmcm_rst_d  = 1'b1;
          clk_ready_d = 1'b0;
          fail_d      = 1'b1;
        end

        default: begin
          state_d     = ST_RST_PULSE;
          pulse_cnt_d = '0;
          mmcm_rst_d  = 1'b1;
          clk_ready_d = 1'b0;
        end
      endcase

      if (tmo_fire) begin
        tmo_cnt_d    = '0;
        stable_cnt_d = '0;
        pulse_cnt_d  = '0;
        mmcm_rst_d   = 1'b1;
        if (retry_cnt_q < RETRY_MAX) begin
          state_d     = ST_RST_PULSE;
          retry_cnt_d = retry_cnt_q + 1'b1;
        end else begin
          state_d = ST_FAIL;
          fail_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RST_PULSE;
      pulse_cnt_q  <= '0;
      stable_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      retry_cnt_q  <= '0;
      loss_cnt_q   <= '0;
      mmcm_rst_q   <= 1'b1;
      clk_ready_q  <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pulse_cnt_q  <= pulse_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
      mmcm_rst_q   <= mmcm_rst_d;
      clk_ready_q  <= clk_ready_d;
      fail_q       <= fail_d;
    end
  end

  assign mmcm_rst  = mmcm_rst_q;
  assign clk_ready = clk_ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_cnt_q;
  assign loss_cnt  = loss_cnt_q;
  assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mmcm_reset_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mmcm_reset_ctrl: event scoreboard bench for the MMCM reset supervisor |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mmcm_reset_ctrl;

  localparam int P   = 4;
  localparam int S   = 8;
  localparam int T   = 50;
  localparam int R   = 2;
  localparam int LAT = 2 + S;

  // Event codes: signal*2 + new level (0 mmcm_rst, 1 clk_ready, 2 fail).
  localparam int EV_RST_FALL  = 0;
  localparam int EV_RST_RISE  = 1;
  localparam int EV_RDY_FALL  = 2;
  localparam int EV_RDY_RISE  = 3;
  localparam int EV_FAIL_FALL = 4;
  localparam int EV_FAIL_RISE = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       soft_rst = 1'b0;
  logic       mmcm_locked = 1'b0;
  logic       mmcm_rst, clk_ready, fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int exp_loss = 0;

  typedef struct {
    string tag;
    int    code;
    int    cyc;
  } sb_item_t;

  sb_item_t sb_q[$];

  logic mon_en = 1'b0;
  logic prev_rst = 1'b1, prev_rdy = 1'b0, prev_fail = 1'b0;

  mmcm_reset_ctrl #(
    .RST_PULSE_CYC    (P),
    .LOCK_STABLE_CYC  (S),
    .LOCK_TIMEOUT_CYC (T),
    .MAX_RETRIES      (R)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .soft_rst    (soft_rst),
    .mmcm_locked (mmcm_locked),
    .mmcm_rst    (mmcm_rst),
    .clk_ready   (clk_ready),
    .fail        (fail),
    .retry_cnt   (retry_cnt),
    .loss_cnt    (loss_cnt),
    .state       (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic sb_push(input string tag, input int code, input int at_cyc);
    sb_item_t it;
    it.tag  = tag;
    it.code = code;
    it.cyc  = at_cyc;
    sb_q.push_back(it);
  endtask

  task automatic sb_pop(input int code);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      check("unexpected_event", code, 32'hFFFF_FFFF);
    end else begin
      it = sb_q.pop_front();
      check({it.tag, "_kind"}, code, it.code);
      check({it.tag, "_cycle"}, cyc, it.cyc);
    end
  endtask

  // Output transitions are sampled on the falling edge and matched in order.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mmcm_rst !== prev_rst)  sb_pop(mmcm_rst  ? EV_RST_RISE  : EV_RST_FALL);
      if (clk_ready !== prev_rdy) sb_pop(clk_ready ? EV_RDY_RISE  : EV_RDY_FALL);
      if (fail !== prev_fail)     sb_pop(fail      ? EV_FAIL_RISE : EV_FAIL_FALL);
    end
    prev_rst  = mmcm_rst;
    prev_rdy  = clk_ready;
    prev_fail = fail;
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic relock(input string tag);
    int c;
    c = cyc;
    mmcm_locked = 1'b1;
    sb_push({tag, "_rdy_rise"}, EV_RDY_RISE, c + LAT);
    wait_until(c + LAT + 1);
  endtask

  task automatic lock_loss(input string tag, output int f);
    int c;
    c = cyc;
    mmcm_locked = 1'b0;
    if (exp_loss < 255) exp_loss++;
    sb_push({tag, "_rst_rise"}, EV_RST_RISE, c + 3);
    sb_push({tag, "_rdy_fall"}, EV_RDY_FALL, c + 3);
    f = c + 3 + P;
    sb_push({tag, "_rst_fall"}, EV_RST_FALL, f);
    wait_until(c + 3);
    check({tag, "_loss_cnt"}, loss_cnt, exp_loss);
    check({tag, "_retry_cnt"}, retry_cnt, 0);
    wait_until(f);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, expected completion before 1000000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, f, r;

    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    check("reset_mmcm_rst",  mmcm_rst,  1);
    check("reset_clk_ready", clk_ready, 0);
    check("reset_fail",      fail,      0);
    check("reset_retry_cnt", retry_cnt, 0);
    check("reset_loss_cnt",  loss_cnt,  0);
    check("reset_state",     state,     0);

    // Normal lock after release
    @(negedge clk);
    c = cyc;
    reset_n = 1'b1;
    sb_push("t1_rst_fall", EV_RST_FALL, c + P);
    wait_until(c + P + 10);
    relock("t1");
    check("t1_retry_cnt", retry_cnt, 0);
    check("t1_state",     state,     3);

    // Lock glitch while qualifying
    c = cyc;
    soft_rst = 1'b1;
    mmcm_locked = 1'b0;
    sb_push("t2_rst_rise", EV_RST_RISE, c + 1);
    sb_push("t2_rdy_fall", EV_RDY_FALL, c + 1);
    sb_push("t2_rst_fall", EV_RST_FALL, c + 1 + P);
    @(negedge clk);
    soft_rst = 1'b0;
    wait_until(c + 1 + P);
    c = cyc;
    mmcm_locked = 1'b1;
    wait_until(c + 5);
    mmcm_locked = 1'b0;
    wait_until(c + 7);
    check("t2_state_stable", state, 2);
    wait_until(c + 8);
    mmcm_locked = 1'b1;
    sb_push("t2_rdy_rise", EV_RDY_RISE, c + 8 + LAT);
    wait_until(c + 9);
    check("t2_state_wait", state, 1);
    wait_until(c + 8 + LAT + 1);
    check("t2_retry_cnt", retry_cnt, 0);
    check("t2_state",     state,     3);

    // No lock: retries then FAIL
    c = cyc;
    soft_rst = 1'b1;
    mmcm_locked = 1'b0;
    sb_push("t3_rst_rise0", EV_RST_RISE, c + 1);
    sb_push("t3_rdy_fall",  EV_RDY_FALL, c + 1);
    f = c + 1 + P;
    sb_push("t3_rst_fall0", EV_RST_FALL, f);
    for (int k = 1; k <= R; k++) begin
      sb_push("t3_rst_rise", EV_RST_RISE, f + T);
      f = f + T + P;
      sb_push("t3_rst_fall", EV_RST_FALL, f);
    end
    sb_push("t3_rst_rise_fail", EV_RST_RISE, f + T);
    sb_push("t3_fail_rise",     EV_FAIL_RISE, f + T);
    @(negedge clk);
    soft_rst = 1'b0;
    r = c + 1 + P + T;
    for (int k = 1; k <= R; k++) begin
      wait_until(r);
      check("t3_retry_step", retry_cnt, k);
      r = r + T + P;
    end
    wait_until(r + 2);
    check("t3_fail",      fail,      1);
    check("t3_mmcm_rst",  mmcm_rst,  1);
    check("t3_state",     state,     4);
    check("t3_retry_cnt", retry_cnt, R);

    // SOFT_RST out of FAIL
    c = cyc;
    soft_rst = 1'b1;
    sb_push("t4_fail_fall", EV_FAIL_FALL, c + 1);
    sb_push("t4_rst_fall",  EV_RST_FALL,  c + 1 + P);
    @(negedge clk);
    soft_rst = 1'b0;
    check("t4_fail",      fail,      0);
    check("t4_retry_cnt", retry_cnt, 0);
    wait_until(c + 1 + P + 10);
    relock("t4");
    check("t4_state",       state,     3);
    check("t4_retry_after", retry_cnt, 0);

    // One timeout before lock leaves RETRY_CNT=1 in RUN
    c = cyc;
    soft_rst = 1'b1;
    mmcm_locked = 1'b0;
    sb_push("t4b_rst_rise", EV_RST_RISE, c + 1);
    sb_push("t4b_rdy_fall", EV_RDY_FALL, c + 1);
    f = c + 1 + P;
    sb_push("t4b_rst_fall",  EV_RST_FALL, f);
    sb_push("t4b_rst_rise2", EV_RST_RISE, f + T);
    sb_push("t4b_rst_fall2", EV_RST_FALL, f + T + P);
    @(negedge clk);
    soft_rst = 1'b0;
    wait_until(f + T + P);
    relock("t4b");
    check("t4b_retry_run", retry_cnt, 1);
    check("t4b_state",     state,     3);

    // Lock loss in RUN clears RETRY_CNT and counts the loss
    lock_loss("t5", f);
    relock("t5");

    // SOFT_RST on the same edge as synchronized lock loss
    c = cyc;
    mmcm_locked = 1'b0;
    sb_push("t6_rst_rise", EV_RST_RISE, c + 3);
    sb_push("t6_rdy_fall", EV_RDY_FALL, c + 3);
    sb_push("t6_rst_fall", EV_RST_FALL, c + 3 + P);
    wait_until(c + 2);
    soft_rst = 1'b1;
    @(negedge clk);
    soft_rst = 1'b0;
    check("t6_loss_cnt", loss_cnt, exp_loss);
    check("t6_state",    state,    0);
    wait_until(c + 3 + P);
    relock("t6");

    // Saturate LOSS_CNT
    for (int i = 0; i < 299; i++) begin
      lock_loss("t5_rep", f);
      relock("t5_rep");
    end
    check("t5_loss_sat", loss_cnt, 255);

    // Asynchronous reset while qualifying lock
    lock_loss("t7", f);
    mmcm_locked = 1'b1;
    wait_until(f + 6);
    check("t7_state_stable", state, 2);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("t7_mmcm_rst",  mmcm_rst,  1);
    check("t7_clk_ready", clk_ready, 0);
    check("t7_fail",      fail,      0);
    check("t7_retry_cnt", retry_cnt, 0);
    check("t7_loss_cnt",  loss_cnt,  0);
    check("t7_state",     state,     0);
    sb_push("t7_rst_rise", EV_RST_RISE, cyc + 1);
    repeat (3) @(negedge clk);
    check("sb_leftover", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
